regfile_wb_arbiter: RTL and testbench

Write-back arbiter that owns the single write port of the 32×32 register file. Each cycle it merges two result sources: single-cycle ALU/load results from the pipeline WB stage, and multi-cycle Booth multiplier results that complete out of order with the pipeline. It buffers multiplier results in a small FIFO and keeps a per-register busy scoreboard so the hazard unit can stall readers of pending multiplier destinations.

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the 32x32 register file. Each cycle it picks
//   the WB-stage ALU/load result if one is present, otherwise drains one
//   buffered multiplier result from a small in-order FIFO. A busy scoreboard
//   marks registers that still have a multiply outstanding.
//
//   Optional build macro: WB_BYPASS_EN -- a multiplier result arriving while
//   the FIFO is empty and no ALU result is present is written straight through
//   (latency 1) instead of being buffered.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   Alu_Valid/Alu_Reg/Alu_Data  WB-stage result, always accepted
//   Issue_Valid/Issue_Reg       multiply issue, marks destination busy
//   Mul_Valid/Mul_Reg/Mul_Data  multiplier result, enqueued when Mul_Ready
//   Mul_Ready                   FIFO has room (combinational from count)
//   RegWrite/Write_Reg/Write_Data  registered register-file write port
//   Busy                        per-register pending-multiply bits
//   Fifo_Count                  occupied FIFO entries
//   Waw_Err                     sticky: ALU wrote a register marked busy
module regfile_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Alu_Valid,
  input  logic [4:0]               Alu_Reg,
  input  logic [DATA_W-1:0]        Alu_Data,
  input  logic                     Issue_Valid,
  input  logic [4:0]               Issue_Reg,
  input  logic                     Mul_Valid,
  input  logic [4:0]               Mul_Reg,
  input  logic [DATA_W-1:0]        Mul_Data,
  output logic                     Mul_Ready,
  output logic                     RegWrite,
  output logic [4:0]               Write_Reg,
  output logic [DATA_W-1:0]        Write_Data,
  output logic [31:0]              Busy,
  output logic [$clog2(DEPTH):0]   Fifo_Count,
  output logic                     Waw_Err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]        mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;

  logic              enq, fifo_empty, pop, bypass, push;
  logic              mul_wr_en;
  logic [4:0]        mul_wr_reg;
  logic [DATA_W-1:0] mul_wr_data;
  logic [31:0]       busy_next;
  logic [PTR_W:0]    cnt_next;

  // Credit depends on the registered count only; a pop in the same cycle
  // does not open a slot until the next cycle.
  assign Mul_Ready = (Fifo_Count < FULL_CNT);

  always_comb begin
    enq        = Mul_Valid && Mul_Ready;
    fifo_empty = (Fifo_Count == '0);
    pop        = !Alu_Valid && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = enq && fifo_empty && !Alu_Valid;
`else
    bypass     = 1'b0;
`endif
    push        = enq && !bypass;
    mul_wr_en   = pop || bypass;
    mul_wr_reg  = pop ? mem_reg[rd_ptr]  : Mul_Reg;
    mul_wr_data = pop ? mem_data[rd_ptr] : Mul_Data;

    // Clear first, then set, so a same-cycle issue to the same register wins.
    busy_next = Busy;
    if (mul_wr_en && (mul_wr_reg != '0))
      busy_next[mul_wr_reg] = 1'b0;
    if (Issue_Valid && (Issue_Reg != '0))
      busy_next[Issue_Reg] = 1'b1;

    cnt_next = Fifo_Count;
    if (push && !pop)
      cnt_next = Fifo_Count + 1'b1;
    else if (!push && pop)
      cnt_next = Fifo_Count - 1'b1;
  end

  // Storage is not reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= Mul_Reg;
      mem_data[wr_ptr] <= Mul_Data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      Fifo_Count <= '0;
      Busy       <= '0;
      Waw_Err    <= 1'b0;
      RegWrite   <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else begin
      Fifo_Count <= cnt_next;
      Busy       <= busy_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (Alu_Valid && (Alu_Reg != '0) && Busy[Alu_Reg])
        Waw_Err <= 1'b1;

      // Writes to r0 are consumed but never reach the register file; the
      // address/data outputs keep their last real write.
      if (Alu_Valid) begin
        RegWrite <= (Alu_Reg != '0);
        if (Alu_Reg != '0) begin
          Write_Reg  <= Alu_Reg;
          Write_Data <= Alu_Data;
        end
      end else if (mul_wr_en) begin
        RegWrite <= (mul_wr_reg != '0);
        if (mul_wr_reg != '0) begin
          Write_Reg  <= mul_wr_reg;
          Write_Data <= mul_wr_data;
        end
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Expected register-file writes are
//   queued as stimulus is issued; an independent monitor compares every
//   RegWrite against the queue. Status outputs are checked inline.
module tb_regfile_wb_arbiter;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              Alu_Valid, Issue_Valid, Mul_Valid;
  logic [4:0]        Alu_Reg, Issue_Reg, Mul_Reg;
  logic [DATA_W-1:0] Alu_Data, Mul_Data;
  logic              Mul_Ready, RegWrite, Waw_Err;
  logic [4:0]        Write_Reg;
  logic [DATA_W-1:0] Write_Data;
  logic [31:0]       Busy;
  logic [$clog2(DEPTH):0] Fifo_Count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .Alu_Valid(Alu_Valid), .Alu_Reg(Alu_Reg), .Alu_Data(Alu_Data),
    .Issue_Valid(Issue_Valid), .Issue_Reg(Issue_Reg),
    .Mul_Valid(Mul_Valid), .Mul_Reg(Mul_Reg), .Mul_Data(Mul_Data),
    .Mul_Ready(Mul_Ready), .RegWrite(RegWrite), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .Busy(Busy), .Fifo_Count(Fifo_Count),
    .Waw_Err(Waw_Err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    Alu_Valid   = 1'b0; Alu_Reg   = '0; Alu_Data = '0;
    Issue_Valid = 1'b0; Issue_Reg = '0;
    Mul_Valid   = 1'b0; Mul_Reg   = '0; Mul_Data = '0;
  endtask

  // Monitor: every registered write must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (RegWrite !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", Write_Reg, Write_Data);
      end else begin
        e = exp_q.pop_front();
        check("wb_reg", 64'(Write_Reg), 64'(e.r));
        check("wb_data", 64'(Write_Data), 64'(e.d));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t, limit 200000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int drain_cnt [5];
    drain_cnt = '{3, 3, 2, 1, 0};

    // Reset with inputs toggling
    idle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Alu_Valid   = 1'($urandom);  Alu_Reg   = 5'($urandom); Alu_Data = $urandom;
      Issue_Valid = 1'($urandom);  Issue_Reg = 5'($urandom);
      Mul_Valid   = 1'($urandom);  Mul_Reg   = 5'($urandom); Mul_Data = $urandom;
      tick();
    end
    check("rst_regwrite", 64'(RegWrite), 0);
    check("rst_write_reg", 64'(Write_Reg), 0);
    check("rst_write_data", 64'(Write_Data), 0);
    check("rst_busy", 64'(Busy), 0);
    check("rst_count", 64'(Fifo_Count), 0);
    check("rst_waw", 64'(Waw_Err), 0);
    check("rst_ready", 64'(Mul_Ready), 1);

    // ALU write on reset release
    idle();
    Alu_Valid = 1'b1; Alu_Reg = 5'd5; Alu_Data = 32'h1234;
    exp_q.push_back('{5'd5, 32'h1234});
    rst = 1'b0;
    tick();
    check("alu_first_regwrite", 64'(RegWrite), 1);
    check("alu_first_reg", 64'(Write_Reg), 5);
    check("alu_first_data", 64'(Write_Data), 32'h1234);

    // Issue r7, then multiplier result
    idle();
    Issue_Valid = 1'b1; Issue_Reg = 5'd7;
    tick();
    idle();
    check("busy7_set", 64'(Busy), 32'h80);
    check("idle_regwrite", 64'(RegWrite), 0);
    Mul_Valid = 1'b1; Mul_Reg = 5'd7; Mul_Data = 32'hDEADBEEF;
    exp_q.push_back('{5'd7, 32'hDEADBEEF});
    tick();
    idle();
`ifdef WB_BYPASS_EN
    check("byp_regwrite", 64'(RegWrite), 1);
    check("byp_reg", 64'(Write_Reg), 7);
    check("byp_busy_clr", 64'(Busy), 0);
    check("byp_count", 64'(Fifo_Count), 0);
`else
    check("mul_lat1_regwrite", 64'(RegWrite), 0);
    check("mul_lat1_count", 64'(Fifo_Count), 1);
    check("mul_lat1_busy", 64'(Busy), 32'h80);
    tick();
    check("mul_lat2_regwrite", 64'(RegWrite), 1);
    check("mul_lat2_reg", 64'(Write_Reg), 7);
    check("mul_busy_clr", 64'(Busy), 0);
    check("mul_lat2_count", 64'(Fifo_Count), 0);
`endif
    tick();
    check("mul_after_regwrite", 64'(RegWrite), 0);

    // ALU held 6 cycles while multiplier results fill the FIFO
    for (int k = 0; k < 6; k++) begin
      Alu_Valid = 1'b1; Alu_Reg = 5'(10 + k); Alu_Data = 32'hA000 + 32'(k);
      exp_q.push_back('{5'(10 + k), 32'hA000 + 32'(k)});
      Mul_Valid = 1'b1;
      if (k < 4) begin
        Mul_Reg = 5'(k + 1); Mul_Data = 32'h1000 + 32'(k + 1);
        check("ready_not_full", 64'(Mul_Ready), 1);
      end else begin
        Mul_Reg = 5'd5; Mul_Data = 32'h5555;
        check("ready_full", 64'(Mul_Ready), 0);
        check("count_full", 64'(Fifo_Count), 4);
      end
      tick();
      check("alu_stream_reg", 64'(Write_Reg), 64'(10 + k));
      check("alu_stream_count", 64'(Fifo_Count), (k < 4) ? 64'(k + 1) : 64'd4);
    end
    Alu_Valid = 1'b0;
    for (int k = 1; k <= 4; k++)
      exp_q.push_back('{5'(k), 32'h1000 + 32'(k)});
    exp_q.push_back('{5'd5, 32'h5555});
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) Mul_Valid = 1'b0;
      check("drain_regwrite", 64'(RegWrite), 1);
      check("drain_reg", 64'(Write_Reg), 64'(k));
      check("drain_count", 64'(Fifo_Count), 64'(drain_cnt[k-1]));
      if (k == 1) check("ready_after_pop", 64'(Mul_Ready), 1);
    end
    idle();
    tick();
    check("drain_done_regwrite", 64'(RegWrite), 0);
    check("no_waw_yet", 64'(Waw_Err), 0);

    // r0 traffic: three batches of three (9 enqueues) wrap the pointers
    for (int b = 0; b < 3; b++) begin
      Alu_Valid = 1'b1; Alu_Reg = 5'd0; Alu_Data = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
        Mul_Valid = 1'b1; Mul_Reg = 5'd0; Mul_Data = 32'hC000 + 32'(3 * b + i);
        tick();
      end
      idle();
      check("r0_fill_count", 64'(Fifo_Count), 3);
      check("r0_alu_regwrite", 64'(RegWrite), 0);
      tick(3);
      check("r0_drain_count", 64'(Fifo_Count), 0);
      check("r0_drain_regwrite", 64'(RegWrite), 0);
      check("r0_hold_reg", 64'(Write_Reg), 5);
      check("r0_hold_data", 64'(Write_Data), 32'h5555);
    end
    Alu_Valid = 1'b1; Alu_Reg = 5'd0;
    Mul_Valid = 1'b1; Mul_Reg = 5'd21; Mul_Data = 32'h2121_2121;
    exp_q.push_back('{5'd21, 32'h2121_2121});
    tick();
    Mul_Reg = 5'd22; Mul_Data = 32'h2222_2222;
    exp_q.push_back('{5'd22, 32'h2222_2222});
    tick();
    idle();
    tick();
    check("wrap_first_reg", 64'(Write_Reg), 21);
    tick();
    check("wrap_second_reg", 64'(Write_Reg), 22);
    check("wrap_count", 64'(Fifo_Count), 0);
    tick();

    // WAW: ALU writes a busy register
    Issue_Valid = 1'b1; Issue_Reg = 5'd9;
    tick();
    idle();
    check("busy9_set", 64'(Busy), 32'h200);
    Alu_Valid = 1'b1; Alu_Reg = 5'd9; Alu_Data = 32'h9999;
    exp_q.push_back('{5'd9, 32'h9999});
    tick();
    idle();
    check("waw_set", 64'(Waw_Err), 1);
    check("waw_alu_regwrite", 64'(RegWrite), 1);
    check("waw_alu_reg", 64'(Write_Reg), 9);
    check("waw_busy_kept", 64'(Busy), 32'h200);
    tick(3);
    check("waw_sticky", 64'(Waw_Err), 1);

    // Reset mid-operation with pending FIFO entries and busy registers
    Issue_Valid = 1'b1; Issue_Reg = 5'd10;
    tick();
    Issue_Reg = 5'd11;
    tick();
    idle();
    Alu_Valid = 1'b1; Alu_Reg = 5'd0;
    for (int i = 0; i < 3; i++) begin
      Mul_Valid = 1'b1; Mul_Reg = 5'(12 + i); Mul_Data = 32'hBAD0 + 32'(i);
      tick();
    end
    idle();
    check("pre_rst_busy", 64'(Busy), 32'h0000_0E00);
    check("pre_rst_count", 64'(Fifo_Count), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(Busy), 0);
    check("async_rst_count", 64'(Fifo_Count), 0);
    check("async_rst_waw", 64'(Waw_Err), 0);
    check("async_rst_write_reg", 64'(Write_Reg), 0);
    check("async_rst_ready", 64'(Mul_Ready), 1);
    tick();
    rst = 1'b0;
    tick(4);
    check("post_rst_regwrite", 64'(RegWrite), 0);
    check("post_rst_count", 64'(Fifo_Count), 0);
    check("post_rst_busy", 64'(Busy), 0);

    check("expected_queue_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
